dist_mem_responder: RTL and testbench



---
 rtl/dist_mem_responder.sv | 132 +++++++++++++
 tb/tb_dist_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_mem_responder.sv
// rtl/dist_mem_responder.sv - distributed-RAM port responder with clear sweep, counters and error flag
module dist_mem_responder #(
    parameter int    ADDR_DEPTH     = 128,
    parameter int    DATA_WIDTH     = 8,
    parameter int    ADDR_WIDTH     = (ADDR_DEPTH > 1) ? $clog2(ADDR_DEPTH) : 1,
    parameter string REGMODE        = "reg",
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter int    CNT_WIDTH      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_clk_en_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_clk_en_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o
);

    // One extra bit so the depth itself is representable when it is a power of two.
    localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(ADDR_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

    logic                  wr_req;
    logic                  rd_req;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  wa;
    logic                  ra;
    logic                  err_event;
    logic [DATA_WIDTH-1:0] rd_word;

    assign busy_o      = (state == ST_CLEAR);

    // A request only exists when its port clock enable is high.
    assign wr_req      = wr_en_i & wr_clk_en_i;
    assign rd_req      = rd_en_i & rd_clk_en_i;
    assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_X);

    assign wa          = wr_req & ~busy_o & wr_in_range;
    assign ra          = rd_req & ~busy_o;

    assign err_event   = (busy_o & (wr_req | rd_req))
                       | (wr_req & ~wr_in_range)
                       | (rd_req & ~rd_in_range);

    // Out-of-range reads return zero instead of indexing past the array.
    assign rd_word     = rd_in_range ? mem[rd_addr_i] : '0;

    // Control FSM: clear sweep sequencing, access counters and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_addr <= '0;
            err_o    <= 1'b0;
            wr_cnt_o <= '0;
            rd_cnt_o <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state <= ST_READY;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
            if (err_event) begin
                err_o <= 1'b1;
            end
            if (wa) begin
                wr_cnt_o <= wr_cnt_o + 1'b1;
            end
            if (ra) begin
                rd_cnt_o <= rd_cnt_o + 1'b1;
            end
        end
    end

    // Storage write port: the sweep owns the array while busy, the write port afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (busy_o) begin
                mem[clr_addr] <= '0;
            end else if (wa) begin
                mem[wr_addr_i] <= wr_data_i;
            end
        end
    end

    generate
        if (REGMODE == "noreg") begin : g_noreg
            // Data is masked during the sweep so outputs read as reset values until it finishes.
            assign rd_data_o  = busy_o ? '0 : rd_word;
            assign rd_valid_o = ra;
        end else begin : g_reg
            // Registered read: samples the array before this edge's write lands (read-before-write).
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    rd_data_o  <= '0;
                    rd_valid_o <= 1'b0;
                end else begin
                    rd_valid_o <= ra;
                    if (ra) begin
                        rd_data_o <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dist_mem_responder.sv
// tb/tb_dist_mem_responder.sv - directed self-checking bench for dist_mem_responder
module tb_dist_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: 128 words, registered read
    logic       a_rst, a_wr_clk_en, a_wr_en, a_rd_clk_en, a_rd_en;
    logic [6:0] a_wr_addr, a_rd_addr;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_busy, a_err;
    logic [15:0] a_wr_cnt, a_rd_cnt;

    // Instance b: 100 words, combinational read
    logic       b_rst, b_wr_clk_en, b_wr_en, b_rd_clk_en, b_rd_en;
    logic [6:0] b_wr_addr, b_rd_addr;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_rd_valid, b_busy, b_err;
    logic [15:0] b_wr_cnt, b_rd_cnt;

    dist_mem_responder #(
        .ADDR_DEPTH(128), .DATA_WIDTH(8), .REGMODE("reg"), .CLEAR_ON_RESET(1'b1), .CNT_WIDTH(16)
    ) u_a (
        .clk_i(clk), .rst_i(a_rst),
        .wr_clk_en_i(a_wr_clk_en), .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
        .rd_clk_en_i(a_rd_clk_en), .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr),
        .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid), .busy_o(a_busy), .err_o(a_err),
        .wr_cnt_o(a_wr_cnt), .rd_cnt_o(a_rd_cnt)
    );

    dist_mem_responder #(
        .ADDR_DEPTH(100), .DATA_WIDTH(8), .REGMODE("noreg"), .CLEAR_ON_RESET(1'b1), .CNT_WIDTH(16)
    ) u_b (
        .clk_i(clk), .rst_i(b_rst),
        .wr_clk_en_i(b_wr_clk_en), .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
        .rd_clk_en_i(b_rd_clk_en), .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid), .busy_o(b_busy), .err_o(b_err),
        .wr_cnt_o(b_wr_cnt), .rd_cnt_o(b_rd_cnt)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] ref_a [128];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic a_idle();
        a_wr_clk_en = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_rd_clk_en = 1'b0; a_rd_en = 1'b0; a_rd_addr = '0;
    endtask

    task automatic b_idle();
        b_wr_clk_en = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_rd_clk_en = 1'b0; b_rd_en = 1'b0; b_rd_addr = '0;
    endtask

    // Back-to-back reads of n words starting at first; each result checked one cycle later.
    task automatic a_read_seq(input int first, input int n);
        a_rd_en = 1'b1; a_rd_clk_en = 1'b1; a_rd_addr = 7'(first);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chk("a_seq_valid", 32'(a_rd_valid), 32'd1);
            chk("a_seq_data", 32'(a_rd_data), 32'(ref_a[first + i - 1]));
            if (i < n) begin
                a_rd_addr = 7'(first + i);
            end else begin
                a_rd_en = 1'b0; a_rd_clk_en = 1'b0;
            end
        end
        @(negedge clk);
        chk("a_seq_valid_drop", 32'(a_rd_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        a_rst = 1'b1; b_rst = 1'b1;
        a_idle(); b_idle();
        for (int i = 0; i < 128; i++) ref_a[i] = 8'h00;
        repeat (2) @(negedge clk);

        chk("a_rst_data", 32'(a_rd_data), 32'd0);
        chk("a_rst_valid", 32'(a_rd_valid), 32'd0);
        chk("a_rst_err", 32'(a_err), 32'd0);
        chk("a_rst_wr_cnt", 32'(a_wr_cnt), 32'd0);
        chk("a_rst_rd_cnt", 32'(a_rd_cnt), 32'd0);
        chk("a_rst_busy", 32'(a_busy), 32'd1);
        chk("b_rst_busy", 32'(b_busy), 32'd1);
        chk("b_rst_data", 32'(b_rd_data), 32'd0);

        // Clear sweep; a write with clock enable low on a, a real write on b, both while busy
        a_rst = 1'b0; b_rst = 1'b0;
        cnt = 0;
        while (a_busy && cnt < 1000) begin
            if (cnt == 3) begin a_wr_en = 1'b1; a_wr_clk_en = 1'b0; a_wr_addr = 7'd1; a_wr_data = 8'h55; end
            if (cnt == 5) begin
                a_wr_en = 1'b0;
                b_wr_en = 1'b1; b_wr_clk_en = 1'b1; b_wr_addr = 7'd7; b_wr_data = 8'hFF;
            end
            if (cnt == 6) begin b_wr_en = 1'b0; b_wr_clk_en = 1'b0; end
            cnt++;
            @(negedge clk);
        end
        a_idle();
        chk("a_clear_cycles", 32'(cnt), 32'd128);
        chk("a_err_after_clear", 32'(a_err), 32'd0);
        chk("b_err_busy_req", 32'(b_err), 32'd1);
        chk("b_wr_cnt_busy_req", 32'(b_wr_cnt), 32'd0);

        // Everything reads back zero after the sweep
        a_read_seq(0, 128);
        chk("a_rd_cnt_128", 32'(a_rd_cnt), 32'd128);
        chk("a_err_clean", 32'(a_err), 32'd0);

        // Random fill then sequential readback
        for (int i = 0; i < 128; i++) begin
            a_wr_en = 1'b1; a_wr_clk_en = 1'b1; a_wr_addr = 7'(i);
            a_wr_data = 8'($urandom);
            ref_a[i] = a_wr_data;
            @(negedge clk);
        end
        a_idle();
        chk("a_wr_cnt_128", 32'(a_wr_cnt), 32'd128);
        a_read_seq(0, 128);
        chk("a_rd_cnt_256", 32'(a_rd_cnt), 32'd256);

        // Read-before-write collision at address 5
        a_wr_en = 1'b1; a_wr_clk_en = 1'b1; a_wr_addr = 7'd5; a_wr_data = 8'h3C;
        ref_a[5] = 8'h3C;
        @(negedge clk);
        a_wr_data = 8'hA5;
        a_rd_en = 1'b1; a_rd_clk_en = 1'b1; a_rd_addr = 7'd5;
        @(negedge clk);
        chk("a_collision_old", 32'(a_rd_data), 32'h3C);
        chk("a_collision_valid", 32'(a_rd_valid), 32'd1);
        ref_a[5] = 8'hA5;
        a_wr_en = 1'b0; a_wr_clk_en = 1'b0;
        @(negedge clk);
        chk("a_collision_new", 32'(a_rd_data), 32'hA5);
        a_idle();
        chk("a_wr_cnt_130", 32'(a_wr_cnt), 32'd130);
        chk("a_rd_cnt_258", 32'(a_rd_cnt), 32'd258);

        // Clock-enable-low requests are ignored
        a_wr_en = 1'b1; a_wr_clk_en = 1'b0; a_wr_addr = 7'd9; a_wr_data = ~ref_a[9];
        @(negedge clk);
        a_idle();
        chk("a_ce_wr_cnt", 32'(a_wr_cnt), 32'd130);
        chk("a_ce_err", 32'(a_err), 32'd0);
        a_rd_en = 1'b1; a_rd_clk_en = 1'b0; a_rd_addr = 7'd9;
        @(negedge clk);
        a_idle();
        chk("a_ce_rd_valid", 32'(a_rd_valid), 32'd0);
        chk("a_ce_rd_hold", 32'(a_rd_data), 32'hA5);
        chk("a_ce_rd_cnt", 32'(a_rd_cnt), 32'd258);
        a_read_seq(9, 1);
        chk("a_rd_cnt_259", 32'(a_rd_cnt), 32'd259);

        // Reset while a read is being issued discards it
        a_rd_en = 1'b1; a_rd_clk_en = 1'b1; a_rd_addr = 7'd9;
        a_rst = 1'b1;
        @(negedge clk);
        a_rst = 1'b0;
        a_idle();
        chk("a_midrst_valid", 32'(a_rd_valid), 32'd0);
        chk("a_midrst_data", 32'(a_rd_data), 32'd0);
        chk("a_midrst_rd_cnt", 32'(a_rd_cnt), 32'd0);
        chk("a_midrst_wr_cnt", 32'(a_wr_cnt), 32'd0);
        chk("a_midrst_busy", 32'(a_busy), 32'd1);

        // b: dropped write left address 7 at zero; combinational read path
        b_rd_en = 1'b1; b_rd_clk_en = 1'b1; b_rd_addr = 7'd7;
        #1;
        chk("b_rd7_data", 32'(b_rd_data), 32'd0);
        chk("b_rd7_valid", 32'(b_rd_valid), 32'd1);
        @(negedge clk);
        b_rd_addr = 7'd3;
        b_wr_en = 1'b1; b_wr_clk_en = 1'b1; b_wr_addr = 7'd3; b_wr_data = 8'h5A;
        #1;
        chk("b_rd3_before_edge", 32'(b_rd_data), 32'd0);
        @(negedge clk);
        b_wr_en = 1'b0; b_wr_clk_en = 1'b0;
        #1;
        chk("b_rd3_after_edge", 32'(b_rd_data), 32'h5A);
        chk("b_rd3_valid", 32'(b_rd_valid), 32'd1);
        @(negedge clk);
        b_idle();
        #1;
        chk("b_idle_valid", 32'(b_rd_valid), 32'd0);
        chk("b_rd_cnt_3", 32'(b_rd_cnt), 32'd3);
        chk("b_wr_cnt_1", 32'(b_wr_cnt), 32'd1);

        // b: reset mid-read, sweep restarts from zero
        @(negedge clk);
        b_rd_en = 1'b1; b_rd_clk_en = 1'b1; b_rd_addr = 7'd3;
        b_rst = 1'b1;
        @(negedge clk);
        b_idle();
        #1;
        chk("b_midrst_data", 32'(b_rd_data), 32'd0);
        chk("b_midrst_valid", 32'(b_rd_valid), 32'd0);
        chk("b_midrst_busy", 32'(b_busy), 32'd1);
        chk("b_midrst_err", 32'(b_err), 32'd0);
        chk("b_midrst_rd_cnt", 32'(b_rd_cnt), 32'd0);
        chk("b_midrst_wr_cnt", 32'(b_wr_cnt), 32'd0);
        @(negedge clk);
        b_rst = 1'b0;
        cnt = 0;
        while (b_busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        chk("b_clear_cycles", 32'(cnt), 32'd100);
        chk("b_err_after_clear", 32'(b_err), 32'd0);
        b_rd_en = 1'b1; b_rd_clk_en = 1'b1; b_rd_addr = 7'd3;
        #1;
        chk("b_rd3_cleared", 32'(b_rd_data), 32'd0);
        @(negedge clk);
        b_idle();

        // b: out-of-range write and read
        b_wr_en = 1'b1; b_wr_clk_en = 1'b1; b_wr_addr = 7'd100; b_wr_data = 8'h11;
        @(negedge clk);
        b_idle();
        chk("b_oor_wr_cnt", 32'(b_wr_cnt), 32'd0);
        chk("b_oor_wr_err", 32'(b_err), 32'd1);
        b_rd_en = 1'b1; b_rd_clk_en = 1'b1; b_rd_addr = 7'd120;
        #1;
        chk("b_oor_rd_data", 32'(b_rd_data), 32'd0);
        chk("b_oor_rd_valid", 32'(b_rd_valid), 32'd1);
        @(negedge clk);
        b_idle();
        chk("b_oor_rd_cnt", 32'(b_rd_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
